mem_port_arbiter: RTL and testbench

//  Shares the single-ported instruction/data memory between the control unit's fetch path and its data path.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DATA_W      = 12;
  localparam int          DEF_WAIT_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   f_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_owner,
`endif
  output logic   valid,
  output owner_t owner
);

  always_comb begin
    valid = f_req | d_req;
    owner = OWN_FETCH;
`ifdef MEM_ARB_RR_EN
    if (f_req && d_req) begin
      // The port granted last time loses the tie.
      if (last_owner == OWN_DATA) begin
        owner = OWN_FETCH;
      end else begin
        owner = OWN_DATA;
      end
    end else if (d_req) begin
      owner = OWN_DATA;
    end
`else
    if (d_req) begin
      owner = OWN_DATA;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data paths: one access at a time,
// WAIT_CYCLES of mem_en per access, done pulse afterwards. Optional macro: MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_rwb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rwb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (WAIT_CYCLES < 1) begin : g_wait_check
    $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
  end

  localparam int unsigned     CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  owner_t            owner_q, owner_nx;
  logic              pick_valid;
  owner_t            pick_owner;

  logic              f_gnt_nx, d_gnt_nx, f_done_nx, d_done_nx;
  logic              mem_en_nx, mem_rwb_nx, busy_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx, f_rdata_nx, d_rdata_nx;

`ifdef MEM_ARB_RR_EN
  owner_t            last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_DATA;
    end else if (state == IDLE && pick_valid) begin
      last_owner <= pick_owner;
    end
  end
`endif

  mem_arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  // The memory strobe registers double as the latched request, so late
  // changes on the requester's address/data never reach the access in flight.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    owner_nx     = owner_q;
    f_gnt_nx     = 1'b0;
    d_gnt_nx     = 1'b0;
    f_done_nx    = 1'b0;
    d_done_nx    = 1'b0;
    mem_en_nx    = 1'b0;
    mem_rwb_nx   = RW_READ;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = '0;
    f_rdata_nx   = f_rdata;
    d_rdata_nx   = d_rdata;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx  = ACCESS;
          cnt_nx    = CNT_LOAD;
          owner_nx  = pick_owner;
          mem_en_nx = 1'b1;
          if (pick_owner == OWN_DATA) begin
            d_gnt_nx     = 1'b1;
            mem_rwb_nx   = d_rwb;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = (d_rwb == RW_WRITE) ? d_wdata : '0;
          end else begin
            f_gnt_nx    = 1'b1;
            mem_addr_nx = f_addr;
          end
        end
      end

      ACCESS: begin
        mem_en_nx    = 1'b1;
        mem_rwb_nx   = mem_rwb;
        mem_wdata_nx = mem_wdata;
        if (cnt == '0) begin
          state_nx     = DONE;
          mem_en_nx    = 1'b0;
          mem_rwb_nx   = RW_READ;
          mem_wdata_nx = '0;
          if (owner_q == OWN_FETCH) begin
            f_done_nx  = 1'b1;
            f_rdata_nx = mem_rdata;
          end else begin
            d_done_nx = 1'b1;
            if (mem_rwb == RW_READ) begin
              d_rdata_nx = mem_rdata;
            end
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_q   <= OWN_FETCH;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_rwb   <= RW_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      owner_q   <= owner_nx;
      f_gnt     <= f_gnt_nx;
      d_gnt     <= d_gnt_nx;
      f_done    <= f_done_nx;
      d_done    <= d_done_nx;
      f_rdata   <= f_rdata_nx;
      d_rdata   <= d_rdata_nx;
      mem_en    <= mem_en_nx;
      mem_rwb   <= mem_rwb_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected accesses,
// a negedge monitor checks grants, memory strobes and done/rdata against them.
module tb_mem_port_arbiter;

  localparam int WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_done;
  logic [7:0]  f_addr;
  logic [11:0] f_rdata;
  logic        d_req, d_rwb, d_gnt, d_done;
  logic [7:0]  d_addr;
  logic [11:0] d_wdata, d_rdata;
  logic        mem_en, mem_rwb, busy;
  logic [7:0]  mem_addr;
  logic [11:0] mem_wdata, mem_rdata;

  logic [11:0] mem_arr [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(12), .WAIT_CYCLES(WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_done    (f_done),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_rwb     (d_rwb),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_rwb   (mem_rwb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Simple memory model: preloaded words, writes land on the clock edge.
  assign mem_rdata = mem_arr[mem_addr];

  initial begin
    foreach (mem_arr[i]) mem_arr[i] = 12'h000;
    mem_arr[8'h05] = 12'h1A3;
    mem_arr[8'h07] = 12'h2E4;
    mem_arr[8'h09] = 12'h777;
    mem_arr[8'h30] = 12'h5C1;
    forever begin
      @(posedge clk);
      if (mem_en && !mem_rwb) mem_arr[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    bit          is_data;
    bit          rwb;
    logic [7:0]  addr;
    logic [11:0] wdata;
    logic [11:0] exp_f;
    logic [11:0] exp_d;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  bit   in_flight = 1'b0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 1'b0;
    end else begin
      if (f_gnt || d_gnt) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_gnt: f_gnt=%0b d_gnt=%0b, no access expected (t=%0t)", f_gnt, d_gnt, $time);
        end else begin
          cur = exp_q.pop_front();
          check("gnt_owner", 32'(d_gnt), 32'(cur.is_data));
          check("gnt_one_hot", 32'(f_gnt & d_gnt), 32'd0);
          in_flight = 1'b1;
          gnt_cyc   = cyc;
        end
      end
      if (in_flight) check("busy", 32'(busy), 32'd1);
      if (in_flight && mem_en) begin
        check("mem_rwb", 32'(mem_rwb), 32'(cur.rwb));
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        check("mem_wdata", 32'(mem_wdata), cur.rwb ? 32'd0 : 32'(cur.wdata));
      end
      if (!(mem_en && !mem_rwb)) check("mem_wdata_zero", 32'(mem_wdata), 32'd0);
      if (f_done || d_done) begin
        if (!in_flight) begin
          n_checks++;
          $display("FAIL unexpected_done: f_done=%0b d_done=%0b, no access in flight (t=%0t)", f_done, d_done, $time);
        end else begin
          check("done_owner", 32'(d_done), 32'(cur.is_data));
          check("done_one_hot", 32'(f_done & d_done), 32'd0);
          check("done_latency", 32'(cyc - gnt_cyc), 32'(WAIT));
          check("mem_en_at_done", 32'(mem_en), 32'd0);
          check("f_rdata", 32'(f_rdata), 32'(cur.exp_f));
          check("d_rdata", 32'(d_rdata), 32'(cur.exp_d));
          in_flight = 1'b0;
        end
      end
    end
  end

  task automatic push(input bit is_data, input bit rwb, input logic [7:0] a,
                      input logic [11:0] w, input logic [11:0] ef, input logic [11:0] ed);
    txn_t t;
    t.is_data = is_data;
    t.rwb     = rwb;
    t.addr    = a;
    t.wdata   = w;
    t.exp_f   = ef;
    t.exp_d   = ed;
    exp_q.push_back(t);
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(f_gnt || d_gnt) && n < 30);
    if (!(f_gnt || d_gnt)) check("gnt_timeout", 32'(f_gnt | d_gnt), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 30);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rwb", 32'(mem_rwb), 32'd1);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_f_rdata", 32'(f_rdata), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);
    check("rst_pulses", 32'({f_gnt, d_gnt, f_done, d_done}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_rwb = 1'b1;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // Fetch read of 0x05
    push(1'b0, 1'b1, 8'h05, 12'h000, 12'h1A3, 12'h000);
    f_addr = 8'h05; f_req = 1'b1;
    wait_gnt(n);
    check("fetch_gnt_latency", 32'(n), 32'd1);
    f_req = 1'b0;
    wait_idle();

    // Data write 0xABC to 0x20; wdata changed after grant must not matter
    push(1'b1, 1'b0, 8'h20, 12'hABC, 12'h1A3, 12'h000);
    d_rwb = 1'b0; d_addr = 8'h20; d_wdata = 12'hABC; d_req = 1'b1;
    wait_gnt(n);
    check("write_gnt_latency", 32'(n), 32'd1);
    d_req = 1'b0; d_wdata = 12'h555; d_addr = 8'h21;
    wait_idle();

    // Data read back of 0x20
    push(1'b1, 1'b1, 8'h20, 12'h000, 12'h1A3, 12'hABC);
    d_rwb = 1'b1; d_addr = 8'h20; d_req = 1'b1;
    wait_gnt(n);
    d_req = 1'b0;
    wait_idle();

    // Fetch address changed after grant
    push(1'b0, 1'b1, 8'h05, 12'h000, 12'h1A3, 12'hABC);
    f_addr = 8'h05; f_req = 1'b1;
    wait_gnt(n);
    f_addr = 8'h09; f_req = 1'b0;
    wait_idle();

    // Fetch request held through done: back-to-back accesses
    push(1'b0, 1'b1, 8'h07, 12'h000, 12'h2E4, 12'hABC);
    push(1'b0, 1'b1, 8'h07, 12'h000, 12'h2E4, 12'hABC);
    f_addr = 8'h07; f_req = 1'b1;
    wait_gnt(n);
    wait_gnt(n);
    check("b2b_gnt_interval", 32'(n), 32'd6);
    f_req = 1'b0;
    wait_idle();

    // Reset pulse, then simultaneous requests
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    push(1'b0, 1'b1, 8'h05, 12'h000, 12'h1A3, 12'h000);
    push(1'b1, 1'b1, 8'h30, 12'h000, 12'h1A3, 12'h5C1);
`else
    push(1'b1, 1'b1, 8'h30, 12'h000, 12'h000, 12'h5C1);
    push(1'b0, 1'b1, 8'h05, 12'h000, 12'h1A3, 12'h5C1);
`endif
    f_addr = 8'h05; d_addr = 8'h30; d_rwb = 1'b1;
    f_req = 1'b1; d_req = 1'b1;
    wait_gnt(n);
    check("tie_gnt_latency", 32'(n), 32'd1);
`ifdef MEM_ARB_RR_EN
    f_req = 1'b0;
`else
    d_req = 1'b0;
`endif
    wait_gnt(n);
    check("tie_second_gnt", 32'(n), 32'd6);
    f_req = 1'b0; d_req = 1'b0;
    wait_idle();

    // Reset during the second ACCESS cycle abandons the access
    push(1'b0, 1'b1, 8'h09, 12'h000, 12'h000, 12'h000);
    f_addr = 8'h09; f_req = 1'b1;
    wait_gnt(n);
    f_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_after_abandon", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
